// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA text-mode pixel pipeline.
package cga_pkg;
  localparam int CHAR_W  = 8;
  localparam int FONT_AW = 11;

  typedef logic [3:0] irgb_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CHAR = 2'd1,
    RD_ATTR = 2'd2,
    LATCH   = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/cga_pix_shifter.sv
// 8-bit MSB-first pixel shifter; hres_40_i halves the shift rate.
// msb_o/done_o describe the state after the coming edge so the caller can register pixels with no extra delay.
module cga_pix_shifter
  import cga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              hres_40_i,
  input  logic [CHAR_W-1:0] data_i,
  output logic              msb_o,
  output logic              done_o
);
  logic [CHAR_W-1:0] sr_q, sr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ph_q, ph_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (cnt_q != 4'(CHAR_W)) begin
      if (hres_40_i && !ph_q) begin
        ph_d = 1'b1;
      end else begin
        sr_d  = {sr_q[CHAR_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        ph_d  = 1'b0;
      end
    end
  end

  // Count starts exhausted so nothing is drawn before the first load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= 4'(CHAR_W);
      ph_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  assign msb_o  = sr_d[CHAR_W-1];
  assign done_o = (cnt_d == 4'(CHAR_W));
endmodule

// File: rtl/cga_text_serializer.sv
// CGA text pipeline: VRAM char/attr fetch, font lookup, IRGB pixel serialization.
// Optional macro CGA_TEXT_BLINK_EN turns attr[7] into blink enable driven by a vsync frame counter.
module cga_text_serializer
  import cga_pkg::*;
#(
  parameter int FONT_ROWS = 8,
  parameter int VRAM_AW   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               divclk,
  input  logic               hres_40,
  input  logic [13:0]        mem_addr,
  input  logic [4:0]         row_addr,
  input  logic               display_enable,
  input  logic               cursor,
  input  logic               vsync,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_rd,
  input  logic [7:0]         vram_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic [3:0]         pix,
  output logic               de_out,
  output logic [1:0]         fetch_state
);
  localparam int ROW_BITS = $clog2(FONT_ROWS);

  fetch_state_e        state_q;
  logic [13:0]         s1_ma_q;
  logic [ROW_BITS-1:0] s1_row_q;
  logic                s1_de_q, s1_cur_q;
  logic [VRAM_AW-1:0]  vram_addr_q;
  logic                vram_rd_q;
  logic [FONT_AW-1:0]  font_q, font_rd;
  logic [7:0]          s2_attr_q, s2_glyph_q;
  logic                s2_de_q, s2_cur_q;
  logic                unused_row;

  assign unused_row = ^row_addr;
  assign font_rd    = FONT_AW'({vram_data, s1_row_q});

  // A strobe always wins: an unfinished fetch is dropped and stage 2 keeps its old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_ma_q     <= '0;
      s1_row_q    <= '0;
      s1_de_q     <= 1'b0;
      s1_cur_q    <= 1'b0;
      vram_addr_q <= '0;
      vram_rd_q   <= 1'b0;
      font_q      <= '0;
      s2_attr_q   <= '0;
      s2_glyph_q  <= '0;
      s2_de_q     <= 1'b0;
      s2_cur_q    <= 1'b0;
    end else if (divclk) begin
      state_q     <= RD_CHAR;
      s1_ma_q     <= mem_addr;
      s1_row_q    <= row_addr[ROW_BITS-1:0];
      s1_de_q     <= display_enable;
      s1_cur_q    <= cursor;
      vram_addr_q <= VRAM_AW'({mem_addr, 1'b0});
      vram_rd_q   <= 1'b1;
    end else begin
      case (state_q)
        RD_CHAR: begin
          state_q     <= RD_ATTR;
          vram_addr_q <= VRAM_AW'({s1_ma_q, 1'b1});
        end
        RD_ATTR: begin
          state_q   <= LATCH;
          font_q    <= font_rd;
          vram_rd_q <= 1'b0;
        end
        LATCH: begin
          state_q    <= IDLE;
          s2_attr_q  <= vram_data;
          s2_glyph_q <= font_data;
          s2_de_q    <= s1_de_q;
          s2_cur_q   <= s1_cur_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Char byte goes straight to the font ROM so the glyph row is ready alongside the attribute.
  assign font_addr   = (state_q == RD_ATTR) ? font_rd : font_q;
  assign vram_addr   = vram_addr_q;
  assign vram_rd     = vram_rd_q;
  assign fetch_state = state_q;

  logic       shift_msb, shift_done;
  logic [7:0] px_attr_q, px_attr_d;
  logic       px_de_q, px_de_d, px_cur_q, px_cur_d;
  logic       blink_on, fg_sel;
  irgb_t      fg, bg, pix_q, pix_d;
  logic       de_q, de_d;

  cga_pix_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (divclk),
    .hres_40_i (hres_40),
    .data_i    (s2_glyph_q),
    .msb_o     (shift_msb),
    .done_o    (shift_done)
  );

  always_comb begin
    px_attr_d = px_attr_q;
    px_de_d   = px_de_q;
    px_cur_d  = px_cur_q;
    if (divclk) begin
      px_attr_d = s2_attr_q;
      px_de_d   = s2_de_q;
      px_cur_d  = s2_cur_q;
    end
  end

`ifdef CGA_TEXT_BLINK_EN
  logic       vsync_q;
  logic [4:0] frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      frame_q <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) frame_q <= frame_q + 5'd1;
    end
  end

  assign blink_on = px_attr_d[7] & frame_q[4];
  assign bg       = {1'b0, px_attr_d[6:4]};
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign blink_on     = 1'b0;
  assign bg           = px_attr_d[7:4];
`endif

  // Cursor forces foreground and is never blinked.
  assign fg     = px_attr_d[3:0];
  assign fg_sel = (shift_msb & ~blink_on) | px_cur_d;
  assign de_d   = px_de_d & ~shift_done;
  assign pix_d  = de_d ? (fg_sel ? fg : bg) : irgb_t'(0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_attr_q <= '0;
      px_de_q   <= 1'b0;
      px_cur_q  <= 1'b0;
      pix_q     <= '0;
      de_q      <= 1'b0;
    end else begin
      px_attr_q <= px_attr_d;
      px_de_q   <= px_de_d;
      px_cur_q  <= px_cur_d;
      pix_q     <= pix_d;
      de_q      <= de_d;
    end
  end

  assign pix    = pix_q;
  assign de_out = de_q;
endmodule

// File: tb/tb_cga_text_serializer.sv
// Directed bench for cga_text_serializer with VRAM and registered font ROM models.
module tb_cga_text_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        divclk = 1'b0;
  logic        hres_40 = 1'b0;
  logic [13:0] mem_addr = '0;
  logic [4:0]  row_addr = 5'd2;
  logic        display_enable = 1'b0;
  logic        cursor = 1'b0;
  logic        vsync = 1'b0;
  logic [14:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [3:0]  pix;
  logic        de_out;
  logic [1:0]  fetch_state;

  logic [7:0] vram [0:32767];
  logic [7:0] rom  [0:2047];

  int n_checks = 0;
  int n_fail   = 0;

  cga_text_serializer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .divclk         (divclk),
    .hres_40        (hres_40),
    .mem_addr       (mem_addr),
    .row_addr       (row_addr),
    .display_enable (display_enable),
    .cursor         (cursor),
    .vsync          (vsync),
    .vram_addr      (vram_addr),
    .vram_rd        (vram_rd),
    .vram_data      (vram_data),
    .font_addr      (font_addr),
    .font_data      (font_data),
    .pix            (pix),
    .de_out         (de_out),
    .fetch_state    (fetch_state)
  );

  // Clock and memory models: both memories answer one clk after the address.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_rd) vram_data <= vram[vram_addr];
    font_data <= rom[font_addr];
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One character window: strobe now, then check the previous character's pixels and this fetch.
  task automatic do_char(input string tag, input logic [13:0] ma, input logic de,
                         input logic cur, input logic h40, input logic [14:0] exp_a0,
                         input logic [10:0] exp_font, input logic [31:0] exp_px,
                         input logic exp_de);
    int period;
    int idx;
    period         = h40 ? 16 : 8;
    mem_addr       = ma;
    display_enable = de;
    cursor         = cur;
    hres_40        = h40;
    divclk         = 1'b1;
    for (int k = 0; k < period; k++) begin
      @(posedge clk);
      #1;
      divclk = 1'b0;
      idx = h40 ? k / 2 : k;
      check($sformatf("%s pix[%0d]", tag, k), 16'(pix), 16'(exp_px[31-4*idx -: 4]));
      check($sformatf("%s de_out[%0d]", tag, k), 16'(de_out), 16'(exp_de));
      check($sformatf("%s vram_rd[%0d]", tag, k), 16'(vram_rd), 16'(k < 2));
      if (k == 0) check($sformatf("%s vram_addr0", tag), 16'(vram_addr), 16'(exp_a0));
      if (k == 1) begin
        check($sformatf("%s vram_addr1", tag), 16'(vram_addr), 16'(exp_a0 + 15'd1));
        check($sformatf("%s font_addr", tag), 16'(font_addr), 16'(exp_font));
      end
    end
  endtask

  task automatic vsync_pulses(input int n);
    repeat (n) begin
      vsync = 1'b1;
      tick(1);
      vsync = 1'b0;
      tick(1);
    end
  endtask

  logic [31:0] blink_px;

  initial begin
    for (int i = 0; i < 32768; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    vram[15'h0020] = 8'h41; vram[15'h0021] = 8'h1E;
    vram[15'h0040] = 8'h00; vram[15'h0041] = 8'h07;
    vram[15'h0060] = 8'h41; vram[15'h0061] = 8'h1E;
    vram[15'h7FFE] = 8'h42; vram[15'h7FFF] = 8'h8F;
    vram[15'h0000] = 8'h41; vram[15'h0001] = 8'h1E;
    rom[11'h20A] = 8'h7E;
    rom[11'h002] = 8'h00;
    rom[11'h212] = 8'hFF;
`ifdef CGA_TEXT_BLINK_EN
    blink_px = 32'h0000_0000;
`else
    blink_px = 32'hFFFF_FFFF;
`endif

    // Reset state
    tick(2);
    check("rst pix", 16'(pix), 16'h0);
    check("rst de_out", 16'(de_out), 16'h0);
    check("rst vram_rd", 16'(vram_rd), 16'h0);
    check("rst vram_addr", 16'(vram_addr), 16'h0);
    check("rst font_addr", 16'(font_addr), 16'h0);
    check("rst state", 16'(fetch_state), 16'h0);
    rst_n = 1'b1;
    tick(3);

    // 80-col basic character, then 40-col doubling
    do_char("c1", 14'h0010, 1'b1, 1'b0, 1'b0, 15'h0020, 11'h20A, 32'h0000_0000, 1'b0);
    do_char("c2", 14'h0010, 1'b1, 1'b0, 1'b0, 15'h0020, 11'h20A, 32'h1EEE_EEE1, 1'b1);
    do_char("c3_40", 14'h0010, 1'b1, 1'b0, 1'b1, 15'h0020, 11'h20A, 32'h1EEE_EEE1, 1'b1);
    do_char("c4_40", 14'h0020, 1'b1, 1'b1, 1'b1, 15'h0040, 11'h002, 32'h1EEE_EEE1, 1'b1);
    // Cursor over blank glyph, then display disabled
    do_char("c5_cur", 14'h0030, 1'b0, 1'b0, 1'b0, 15'h0060, 11'h20A, 32'h7777_7777, 1'b1);
    do_char("c6_de0", 14'h3FFF, 1'b1, 1'b0, 1'b0, 15'h7FFE, 11'h212, 32'h0000_0000, 1'b0);
    // Address wrap and blink-capable attribute
    do_char("c7_wrap", 14'h0000, 1'b1, 1'b0, 1'b0, 15'h0000, 11'h20A, 32'hFFFF_FFFF, 1'b1);
    do_char("c8", 14'h3FFF, 1'b1, 1'b0, 1'b0, 15'h7FFE, 11'h212, 32'h1EEE_EEE1, 1'b1);
    do_char("c9_f0", 14'h3FFF, 1'b1, 1'b0, 1'b0, 15'h7FFE, 11'h212, 32'hFFFF_FFFF, 1'b1);
    vsync_pulses(16);
    do_char("c10_f16", 14'h3FFF, 1'b1, 1'b0, 1'b0, 15'h7FFE, 11'h212, blink_px, 1'b1);
    vsync_pulses(16);
    do_char("c11_f32", 14'h3FFF, 1'b1, 1'b0, 1'b0, 15'h7FFE, 11'h212, 32'hFFFF_FFFF, 1'b1);

    // Reset pulsed mid-shift clears outputs immediately
    mem_addr = 14'h3FFF;
    divclk   = 1'b1;
    tick(1);
    divclk = 1'b0;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst pix", 16'(pix), 16'h0);
    check("midrst de_out", 16'(de_out), 16'h0);
    check("midrst vram_rd", 16'(vram_rd), 16'h0);
    check("midrst state", 16'(fetch_state), 16'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    do_char("c13_post", 14'h3FFF, 1'b1, 1'b0, 1'b0, 15'h7FFE, 11'h212, 32'h0000_0000, 1'b0);
    do_char("c14_post", 14'h3FFF, 1'b1, 1'b0, 1'b0, 15'h7FFE, 11'h212, 32'hFFFF_FFFF, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
